// File: rtl/shift_sub_divider_if.sv
// Handshake and operand/result bundle for the shift-subtract divider.
// master: drives start/dividend_in/divisor_in; slave: returns busy/done/quotient/remainder/div_by_zero.
interface shift_sub_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend_in;
    logic [WIDTH-1:0] divisor_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend_in, divisor_in,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend_in, divisor_in,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/shift_sub_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Ports: clk, rst (async active-low), bus (slave: start/operands in, busy/done/results out).
module shift_sub_divider #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_sub_divider_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [WIDTH:0]  a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic            dbz_q;

    logic            accept;
    logic            last;
    logic            fit;
    logic [WIDTH:0]  a_sh;
    logic [WIDTH:0]  t;
    logic [WIDTH:0]  a_nx;
    logic [WIDTH-1:0] q_nx;

    // DONE accepts a new start just like IDLE, so results can stream back to back.
    assign accept = (state != RUN) && bus.start;
    assign last   = (cnt == CW'(WIDTH - 1));

    // Trial subtraction: the top bit of t is the borrow, clear means the divisor fits.
    assign a_sh = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign t    = a_sh - {1'b0, m_q};
    assign fit  = ~t[WIDTH];
    assign a_nx = fit ? t : a_sh;
    assign q_nx = {q_q[WIDTH-2:0], fit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start)
                    state_nx = (bus.divisor_in == '0) ? DONE : RUN;
                else
                    state_nx = IDLE;
            end
            RUN:     state_nx = last ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            q_q    <= '0;
            m_q    <= '0;
            cnt    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= '0;
            q_q   <= bus.dividend_in;
            m_q   <= bus.divisor_in;
            cnt   <= '0;
            dbz_q <= 1'b0;
            // Zero divisor completes immediately with a saturated quotient.
            if (bus.divisor_in == '0) begin
                quot_q <= '1;
                rem_q  <= bus.dividend_in;
                dbz_q  <= 1'b1;
            end
        end else if (state == RUN) begin
            a_q <= a_nx;
            q_q <= q_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                quot_q <= q_nx;
                rem_q  <= a_nx[WIDTH-1:0];
            end
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed testbench for shift_sub_divider (WIDTH=4).
// Drives on falling edges, samples on falling edges; checks latency, handshake and results.
module tb_shift_sub_divider;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;
    int   bcnt;

    shift_sub_divider_if #(.WIDTH(W)) bus ();

    shift_sub_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic launch(input int a, input int b);
        bus.start       = 1'b1;
        bus.dividend_in = W'(a);
        bus.divisor_in  = W'(b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts falling edges until done, bounded; busy cycles tallied on the way.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.dividend_in = '0;
        bus.divisor_in = '0;

        #3;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_q", 32'(bus.quotient), 0);
        chk("rst_r", 32'(bus.remainder), 0);
        chk("rst_dbz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 13/3
        launch(13, 3);
        wait_done(lat, bcnt);
        chk("13/3 lat", 32'(lat), 4);
        chk("13/3 busy_cycles", 32'(bcnt), 4);
        chk("13/3 busy_at_done", 32'(bus.busy), 0);
        chk("13/3 q", 32'(bus.quotient), 4);
        chk("13/3 r", 32'(bus.remainder), 1);
        chk("13/3 dbz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        chk("13/3 done_pulse", 32'(bus.done), 0);
        chk("13/3 q_held", 32'(bus.quotient), 4);

        // 15/1 then 7/9 back to back
        launch(15, 1);
        wait_done(lat, bcnt);
        chk("15/1 lat", 32'(lat), 4);
        chk("15/1 q", 32'(bus.quotient), 15);
        chk("15/1 r", 32'(bus.remainder), 0);
        launch(7, 9);
        chk("b2b busy", 32'(bus.busy), 1);
        chk("b2b done_low", 32'(bus.done), 0);
        chk("b2b q_held", 32'(bus.quotient), 15);
        wait_done(lat, bcnt);
        chk("7/9 lat", 32'(lat), 4);
        chk("7/9 q", 32'(bus.quotient), 0);
        chk("7/9 r", 32'(bus.remainder), 7);
        @(negedge clk);

        // 9/0
        launch(9, 0);
        chk("9/0 busy", 32'(bus.busy), 0);
        wait_done(lat, bcnt);
        chk("9/0 lat", 32'(lat), 0);
        chk("9/0 busy_cycles", 32'(bcnt), 0);
        chk("9/0 q", 32'(bus.quotient), 15);
        chk("9/0 r", 32'(bus.remainder), 9);
        chk("9/0 dbz", 32'(bus.div_by_zero), 1);
        @(negedge clk);
        chk("9/0 done_pulse", 32'(bus.done), 0);

        // 14/4 with an ignored start at edge 2
        launch(14, 4);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend_in = 4'd5;
        bus.divisor_in = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, bcnt);
        chk("14/4 lat", 32'(lat + 2), 4);
        chk("14/4 q", 32'(bus.quotient), 3);
        chk("14/4 r", 32'(bus.remainder), 2);
        chk("14/4 dbz", 32'(bus.div_by_zero), 0);
        @(negedge clk);

        // Asynchronous reset mid-run of 12/5
        launch(12, 5);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst busy", 32'(bus.busy), 0);
        chk("arst done", 32'(bus.done), 0);
        chk("arst q", 32'(bus.quotient), 0);
        chk("arst r", 32'(bus.remainder), 0);
        chk("arst dbz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst idle", 32'(bus.busy), 0);
        launch(12, 5);
        wait_done(lat, bcnt);
        chk("12/5 lat", 32'(lat), 4);
        chk("12/5 q", 32'(bus.quotient), 2);
        chk("12/5 r", 32'(bus.remainder), 2);
        @(negedge clk);

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                launch(a, b);
                wait_done(lat, bcnt);
                if (b == 0) begin
                    chk($sformatf("sw %0d/0 dbz", a), 32'(bus.div_by_zero), 1);
                    chk($sformatf("sw %0d/0 q", a), 32'(bus.quotient), 15);
                    chk($sformatf("sw %0d/0 r", a), 32'(bus.remainder), 32'(a));
                end else begin
                    chk($sformatf("sw %0d/%0d id", a, b),
                        32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
                    chk($sformatf("sw %0d/%0d rlt", a, b),
                        32'(32'(bus.remainder) < 32'(b)), 1);
                    chk($sformatf("sw %0d/%0d q", a, b), 32'(bus.quotient), 32'(a / b));
                    chk($sformatf("sw %0d/%0d dbz", a, b), 32'(bus.div_by_zero), 0);
                end
            end
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
